sha3_digest_reader: RTL and testbench
=====================================

Name: sha3_digest_reader

Overview:
- Consumer on the output side of the Keccak-f[1600] round pipeline.
- Accepts one final 1600-bit state plus the nonce that produced it.
- Extracts the SHA3-256 digest (lanes x=0..3, y=0) and streams nonce and digest as 32-bit beats over a valid/ready interface to the host-facing FIFO/CSR logic.
- Optionally screens digests against a leading-zero difficulty so that only hits are streamed.

Parameters:
- NONCE_W, 32, nonce width; must be 32 (one beat).
- DIGEST_WORDS, 8, 32-bit digest beats per result; fixed 8 for SHA3-256.

Ports:
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- st_valid  in  1  final state and nonce valid
- st_ready  out  1  block can accept a state
- st_data  in  1600  final permutation state; lane (x,y) occupies bits [1599-64*(5y+x) -: 64]
- st_nonce  in  32  nonce associated with st_data
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts beat
- out_data  out  32  beat payload
- out_last  out  1  marks final beat of a result
- busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Digest bytes: b0..b31. Lane x (x=0..3, y=0) supplies b(8x)..b(8x+7). Byte j of a lane is lane bits [8j+7:8j], i.e. little-endian within the lane.
- Beat 0 = st_nonce. Beat k (k=1..8) = {b(4k-4), b(4k-3), b(4k-2), b(4k-1)}, with the lower-numbered byte in bits [31:24].
- Handshake on each interface: a transfer occurs when valid && ready. out_data and out_last stay stable while out_valid=1 && out_ready=0.
- FSM states: IDLE, CHECK, STREAM.
  - IDLE: st_ready=1. On st_valid, register the nonce and the 256 digest bits (the other 1344 bits are discarded) and go to CHECK.
  - CHECK: one cycle; see Optional Feature. Without the feature, always go to STREAM with beat index idx=0.
  - STREAM: out_valid=1, out_data=beat[idx], out_last=(idx==8). On handshake with idx<8, idx increments. On handshake with idx==8, go to IDLE.
- st_ready is 0 in CHECK and STREAM. The next state is accepted no earlier than the cycle after the last beat.
- Latency: st handshake at cycle T gives the first out_valid at T+2. Best-case throughput is one result per 11 cycles.
- idx is a 4-bit counter, range 0..8, and never wraps past 8.
- Reset (any state, including mid-stream) forces IDLE, idx=0, and:
  - st_ready=1 from the first cycle after reset deasserts
  - out_valid=0, out_last=0, out_data=0, busy=0
  - the registered digest and nonce are cleared to 0
  - any partially streamed result is dropped; downstream must tolerate a truncated frame without out_last.
- st_valid while st_ready=0 is ignored. The producer holds it until accepted.

Optional Feature:
- Macro: SHA3_TARGET_CMP_EN.
- Defined:
  - Adds input difficulty [7:0], sampled together with the state at the st handshake.
  - Adds output hit_count [31:0], reset 0, saturating at 32'hFFFFFFFF.
  - In CHECK, lz = number of leading zero bits of the 256-bit string b0..b31, counted from b0 bit 7 and capped at 255.
  - If lz >= difficulty: hit_count increments and the FSM goes to STREAM.
  - Otherwise: the FSM returns to IDLE and nothing is streamed.
  - difficulty=0 always hits.
- Undefined: no difficulty or hit_count ports; every accepted state is streamed.

Test Plan:
- Reset then idle: st_ready=1, out_valid=0, busy=0. Hold out_ready=1 for 20 cycles -> no beats.
- Lane0 = 64'h0706050403020100, lane1 = 64'h0F0E0D0C0B0A0908, st_nonce = 32'hDEADBEEF -> beats: DEADBEEF, 00010203, 04050607, 08090A0B, 0C0D0E0F, then lanes 2–3 bytes; out_last only on beat 9; first out_valid exactly 2 cycles after the st handshake.
- Backpressure: out_ready toggles 1,0,0,1 repeating -> out_data stable while stalled, exactly 9 beats, st_ready low until the cycle after the last handshake.
- Reset asserted during beat 4 -> next cycle out_valid=0, st_ready=1. A new state then streams from beat 0.
- Back-to-back: st_valid held high with two different states -> second accepted only after the first frame's out_last handshake; two complete frames in order.
- SHA3_TARGET_CMP_EN, difficulty=8:
  - b0=8'h00, b1=8'h80 -> lz=8, hit, streamed, hit_count=1.
  - b0=8'h01 -> lz=7, dropped, FSM back to IDLE one cycle after CHECK, hit_count unchanged.

Source files
------------

// File: rtl/sha3_digest_reader_if.sv
// Result-path bundle: final Keccak state plus nonce in, 32-bit nonce/digest beats out.
// slave = the digest reader, master = the producer/consumer pair around it.
interface sha3_digest_reader_if #(
  parameter int NONCE_W = 32
);
  logic               st_valid;
  logic               st_ready;
  logic [1599:0]      st_data;
  logic [NONCE_W-1:0] st_nonce;
  logic               out_valid;
  logic               out_ready;
  logic [31:0]        out_data;
  logic               out_last;

  modport master (
    output st_valid, st_data, st_nonce, out_ready,
    input  st_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  st_valid, st_data, st_nonce, out_ready,
    output st_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/sha3_digest_reader.sv
// Streams nonce + SHA3-256 digest as 9 beats; first beat 2 cycles after accept, stalls on out_ready.
// Optional leading-zero difficulty screen and hit counter under SHA3_TARGET_CMP_EN.
module sha3_digest_reader #(
  parameter int NONCE_W      = 32,
  parameter int DIGEST_WORDS = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  sha3_digest_reader_if.slave     bus,
`ifdef SHA3_TARGET_CMP_EN
  input  logic [7:0]              difficulty,
  output logic [31:0]             hit_count,
`endif
  output logic                    busy
);

  localparam int         DIGEST_W = 32 * DIGEST_WORDS;
  localparam logic [3:0] LAST_IDX = 4'(DIGEST_WORDS);

  typedef enum logic [1:0] {IDLE, CHECK, STREAM} state_t;

  state_t                state_q, state_d;
  logic [3:0]            idx_q, idx_d;
  logic [NONCE_W-1:0]    nonce_q;
  logic [DIGEST_W-1:0]   digest_q;
  logic [DIGEST_W-1:0]   digest_in;
  logic                  st_fire;
  logic                  hit;
  logic                  unused_st_bits;

  // Lanes x=0..3 of row y=0; bytes are little-endian within a lane, b0 lands in the MSB byte.
  always_comb begin
    digest_in = '0;
    for (int x = 0; x < DIGEST_WORDS / 2; x++) begin
      for (int j = 0; j < 8; j++) begin
        digest_in[DIGEST_W-1-8*(8*x+j) -: 8] = bus.st_data[1536-64*x+8*j +: 8];
      end
    end
  end

  assign unused_st_bits = ^bus.st_data[1599-DIGEST_W:0];
  assign st_fire        = bus.st_valid && (state_q == IDLE);
  assign busy           = (state_q != IDLE);

`ifdef SHA3_TARGET_CMP_EN
  logic [7:0] diff_q;
  logic [7:0] lz;
  logic       lz_found;

  // All-zero digest yields 255 so the count fits in 8 bits.
  always_comb begin
    lz       = 8'd255;
    lz_found = 1'b0;
    for (int i = 0; i < DIGEST_W; i++) begin
      if (!lz_found && digest_q[DIGEST_W-1-i]) begin
        lz       = 8'(i);
        lz_found = 1'b1;
      end
    end
  end

  assign hit = (lz >= diff_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      diff_q    <= '0;
      hit_count <= '0;
    end else begin
      if (st_fire) diff_q <= difficulty;
      if (state_q == CHECK && hit && hit_count != 32'hFFFF_FFFF) hit_count <= hit_count + 32'd1;
    end
  end
`else
  assign hit = 1'b1;
`endif

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    bus.st_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_last  = 1'b0;
    case (state_q)
      IDLE: begin
        bus.st_ready = 1'b1;
        if (bus.st_valid) state_d = CHECK;
      end
      CHECK: begin
        idx_d   = '0;
        state_d = hit ? STREAM : IDLE;
      end
      STREAM: begin
        bus.out_valid = 1'b1;
        bus.out_last  = (idx_q == LAST_IDX);
        if (bus.out_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Beat mux reads only registered state, so the payload holds steady through a stall.
  always_comb begin
    bus.out_data = '0;
    if (state_q == STREAM) begin
      if (idx_q == 4'd0) bus.out_data = 32'(nonce_q);
      for (int k = 0; k < DIGEST_WORDS; k++) begin
        if (idx_q == 4'(k + 1)) bus.out_data = digest_q[DIGEST_W-1-32*k -: 32];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      nonce_q  <= '0;
      digest_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (st_fire) begin
        nonce_q  <= bus.st_nonce;
        digest_q <= digest_in;
      end
    end
  end

endmodule

// File: tb/tb_sha3_digest_reader.sv
// Directed bench for sha3_digest_reader: beat order, latency, backpressure, reset, back-to-back.
// Builds with or without SHA3_TARGET_CMP_EN.
module tb_sha3_digest_reader;

  logic clk = 1'b0;
  logic reset;
  logic busy;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sha3_digest_reader_if bus();

`ifdef SHA3_TARGET_CMP_EN
  logic [7:0]  difficulty;
  logic [31:0] hit_count;
`endif

  sha3_digest_reader dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus.slave),
`ifdef SHA3_TARGET_CMP_EN
    .difficulty (difficulty),
    .hit_count  (hit_count),
`endif
    .busy       (busy)
  );

  logic [63:0] vl [5][4];
  logic [31:0] vn [5];
  logic [31:0] ve [5][9];

  logic [31:0] got_dat  [32];
  logic        got_last [32];
  int          ngot;
  int          hs_cyc    [2];
  int          first_cyc [2];
  int          last_cyc  [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [1599:0] mk_state(input int v);
    return {vl[v][0], vl[v][1], vl[v][2], vl[v][3], {21{64'hA5A5_5A5A_C3C3_3C3C}}};
  endfunction

  // Producer and consumer run together so a held st_valid overlaps the stream.
  task automatic run_frames(input int va, input int vb, input int nfr, input int pat);
    int          fr [2];
    int          sent = 0, done = 0, k = 0, bound = 0, ready_bad = 0;
    logic        stalled = 1'b0, seen_first = 1'b0;
    logic [31:0] held_d = '0;
    logic        held_l = 1'b0;
    fr[0] = va;
    fr[1] = vb;
    ngot  = 0;
    while (done < nfr && bound < 200) begin
      if (sent < nfr) begin
        bus.st_valid = 1'b1;
        bus.st_data  = mk_state(fr[sent]);
        bus.st_nonce = vn[fr[sent]];
        if (bus.st_ready) begin
          hs_cyc[sent] = cyc;
          sent++;
        end
      end else begin
        bus.st_valid = 1'b0;
      end
      bus.out_ready = (pat == 0) ? 1'b1 : ((k % 4 == 0) || (k % 4 == 3));
      if (bus.out_valid) begin
        if (!seen_first) begin
          first_cyc[done] = cyc;
          seen_first      = 1'b1;
        end
        if (bus.st_ready) ready_bad++;
        if (stalled) begin
          check("stall_data", bus.out_data, held_d);
          check("stall_last", 32'(bus.out_last), 32'(held_l));
        end
        if (bus.out_ready) begin
          if (ngot < 32) begin
            got_dat[ngot]  = bus.out_data;
            got_last[ngot] = bus.out_last;
          end
          ngot++;
          stalled = 1'b0;
          if (bus.out_last) begin
            last_cyc[done] = cyc;
            done++;
            seen_first = 1'b0;
          end
        end else begin
          stalled = 1'b1;
          held_d  = bus.out_data;
          held_l  = bus.out_last;
        end
      end
      k++;
      bound++;
      @(negedge clk);
    end
    bus.st_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("frames_done", 32'(done), 32'(nfr));
    check("st_ready_low_in_stream", 32'(ready_bad), 32'd0);
  endtask

  task automatic verify_frames(input int va, input int vb, input int nfr);
    int v;
    check("beat_count", 32'(ngot), 32'(9 * nfr));
    for (int i = 0; i < 9 * nfr && i < ngot && i < 32; i++) begin
      v = (i < 9) ? va : vb;
      check($sformatf("beat%0d_data", i), got_dat[i], ve[v][i % 9]);
      check($sformatf("beat%0d_last", i), 32'(got_last[i]), 32'((i % 9) == 8));
    end
    check("latency_first", 32'(first_cyc[0] - hs_cyc[0]), 32'd2);
  endtask

  initial begin
    int cnt;
    int nhs;
    int bound;
    logic hs;

    vl[0] = '{64'h0706050403020100, 64'h0F0E0D0C0B0A0908, 64'h1716151413121110, 64'h1F1E1D1C1B1A1918};
    vn[0] = 32'hDEADBEEF;
    ve[0] = '{32'hDEADBEEF, 32'h00010203, 32'h04050607, 32'h08090A0B, 32'h0C0D0E0F,
              32'h10111213, 32'h14151617, 32'h18191A1B, 32'h1C1D1E1F};
    vl[1] = '{64'h1122334455667788, 64'hFFEEDDCCBBAA9988, 64'h0, 64'h0000000100000000};
    vn[1] = 32'h12345678;
    ve[1] = '{32'h12345678, 32'h88776655, 32'h44332211, 32'h8899AABB, 32'hCCDDEEFF,
              32'h0, 32'h0, 32'h0, 32'h01000000};
    vl[2] = '{64'h0000000000008000, 64'h0, 64'h0, 64'h0};
    vn[2] = 32'hCAFE0001;
    ve[2] = '{32'hCAFE0001, 32'h00800000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    vl[3] = '{64'h0000000000000001, 64'h0, 64'h0, 64'h0};
    vn[3] = 32'h0BADF00D;
    ve[3] = '{32'h0BADF00D, 32'h01000000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    vl[4] = '{64'h00000000000000FF, 64'h0, 64'h0, 64'h0};
    vn[4] = 32'h00000004;
    ve[4] = '{32'h00000004, 32'hFF000000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};

    reset         = 1'b1;
    bus.st_valid  = 1'b0;
    bus.st_data   = '0;
    bus.st_nonce  = '0;
    bus.out_ready = 1'b0;
`ifdef SHA3_TARGET_CMP_EN
    difficulty = 8'd0;
`endif
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_st_ready", 32'(bus.st_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", bus.out_data, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
`ifdef SHA3_TARGET_CMP_EN
    check("rst_hit_count", hit_count, 32'd0);
`endif

    bus.out_ready = 1'b1;
    cnt = 0;
    repeat (20) begin
      if (bus.out_valid) cnt++;
      @(negedge clk);
    end
    check("idle_no_beats", 32'(cnt), 32'd0);
    bus.out_ready = 1'b0;

    run_frames(0, 0, 1, 0);
    verify_frames(0, 0, 1);
    check("post_frame_st_ready", 32'(bus.st_ready), 32'd1);
    check("post_frame_busy", 32'(busy), 32'd0);

    run_frames(1, 1, 1, 1);
    verify_frames(1, 1, 1);
    check("bp_post_st_ready", 32'(bus.st_ready), 32'd1);

    bus.st_valid  = 1'b1;
    bus.st_data   = mk_state(0);
    bus.st_nonce  = vn[0];
    bus.out_ready = 1'b1;
    nhs   = 0;
    bound = 0;
    hs    = 1'b0;
    while (bound < 100 && !(bus.out_valid && nhs == 4)) begin
      if (hs) bus.st_valid = 1'b0;
      if (bus.st_ready && bus.st_valid) hs = 1'b1;
      if (bus.out_valid && bus.out_ready) nhs++;
      bound++;
      @(negedge clk);
    end
    check("mid_reached_beat4", 32'(nhs), 32'd4);
    check("mid_beat4_data", bus.out_data, ve[0][4]);
    bus.st_valid = 1'b0;
    reset        = 1'b1;
    @(negedge clk);
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_st_ready", 32'(bus.st_ready), 32'd1);
    check("mid_rst_out_last", 32'(bus.out_last), 32'd0);
    check("mid_rst_out_data", bus.out_data, 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
`ifdef SHA3_TARGET_CMP_EN
    check("mid_rst_hit_count", hit_count, 32'd0);
`endif
    reset = 1'b0;
    @(negedge clk);
    check("mid_post_st_ready", 32'(bus.st_ready), 32'd1);
    run_frames(1, 1, 1, 0);
    verify_frames(1, 1, 1);

    run_frames(0, 1, 2, 0);
    verify_frames(0, 1, 2);
    check("b2b_second_accept", 32'(hs_cyc[1] - last_cyc[0]), 32'd1);

`ifdef SHA3_TARGET_CMP_EN
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("cmp_rst_hit_count", hit_count, 32'd0);

    difficulty = 8'd8;
    run_frames(2, 2, 1, 0);
    verify_frames(2, 2, 1);
    check("hit_lz8_count", hit_count, 32'd1);

    bus.st_valid = 1'b1;
    bus.st_data  = mk_state(3);
    bus.st_nonce = vn[3];
    bound = 0;
    while (!bus.st_ready && bound < 50) begin
      bound++;
      @(negedge clk);
    end
    check("miss_accept", 32'(bus.st_ready), 32'd1);
    @(negedge clk);
    bus.st_valid = 1'b0;
    check("miss_check_busy", 32'(busy), 32'd1);
    check("miss_check_st_ready", 32'(bus.st_ready), 32'd0);
    @(negedge clk);
    check("miss_idle_busy", 32'(busy), 32'd0);
    check("miss_idle_st_ready", 32'(bus.st_ready), 32'd1);
    bus.out_ready = 1'b1;
    cnt = 0;
    repeat (12) begin
      if (bus.out_valid) cnt++;
      @(negedge clk);
    end
    bus.out_ready = 1'b0;
    check("miss_no_beats", 32'(cnt), 32'd0);
    check("miss_hit_count", hit_count, 32'd1);

    difficulty = 8'd0;
    run_frames(4, 4, 1, 0);
    verify_frames(4, 4, 1);
    check("diff0_hit_count", hit_count, 32'd2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
